// File: rtl/test_monitor.sv
// Simulation end-of-test monitor: per-hart pass/fail/timeout tracking.
// Optional hang detection is compiled in with TEST_MONITOR_STALL_DETECT_EN.
module test_monitor #(
    parameter int unsigned            XLEN        = 32,
    parameter int unsigned            NUM_HARTS   = 1,
    parameter logic [XLEN-1:0]        END_PC      = 'h44,
    parameter int unsigned            RESULT_REG  = 3,
    parameter int unsigned            TIMEOUT     = 5000,
    parameter int unsigned            TIMEOUT_W   = 32,
    parameter int unsigned            STALL_LIMIT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_HARTS*XLEN-1:0] pc,
    input  logic [NUM_HARTS-1:0]      pc_valid,
    input  logic [NUM_HARTS-1:0]      rf_we,
    input  logic [NUM_HARTS*5-1:0]    rf_waddr,
    input  logic [NUM_HARTS*XLEN-1:0] rf_wdata,
    output logic [NUM_HARTS-1:0]      hart_pass,
    output logic [NUM_HARTS-1:0]      hart_fail,
    output logic [NUM_HARTS-1:0]      hart_timeout,
    output logic [NUM_HARTS*XLEN-1:0] fail_code,
    output logic [NUM_HARTS-1:0]      hang,
    output logic                      done,
    output logic                      pass,
    output logic [TIMEOUT_W-1:0]      cycles
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_PASS    = 2'd1;
    localparam logic [1:0] S_FAIL    = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    localparam logic [TIMEOUT_W-1:0] LAST_CYCLE = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [4:0]           RES_IDX    = 5'(RESULT_REG);

    logic [NUM_HARTS-1:0] run_vec;
    logic                 any_run;
    logic                 timeout_hit;

    assign any_run     = |run_vec;
    assign timeout_hit = (cycles == LAST_CYCLE);
    assign done        = ~any_run;
    assign pass        = done & (&hart_pass);

    // Run-cycle counter: counts while any hart runs, saturates, freezes at done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= '0;
        end else if (any_run && (cycles != '1)) begin
            cycles <= cycles + 1'b1;
        end
    end

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic [1:0]      state;
        logic [XLEN-1:0] shadow;
        logic [XLEN-1:0] code;
        logic [XLEN-1:0] hpc;
        logic            end_hit;
        logic            res_write;
        logic            stall_hit;

        assign hpc       = pc[h*XLEN +: XLEN];
        assign end_hit   = pc_valid[h] && (hpc == END_PC);
        assign res_write = rf_we[h] && (rf_waddr[h*5 +: 5] == RES_IDX);

        assign run_vec[h]                 = (state == S_RUN);
        assign hart_pass[h]               = (state == S_PASS);
        assign hart_fail[h]               = (state == S_FAIL);
        assign hart_timeout[h]            = (state == S_TIMEOUT);
        assign fail_code[h*XLEN +: XLEN]  = code;

`ifdef TEST_MONITOR_STALL_DETECT_EN
        localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
        localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

        logic [SW-1:0]   stall_cnt;
        logic [SW-1:0]   stall_next;
        logic [XLEN-1:0] last_pc;
        logic            hang_q;

        // Length of the current run of valid cycles at the same pc.
        assign stall_next = ((stall_cnt != '0) && (hpc == last_pc))
                          ? stall_cnt + 1'b1 : SW'(1);
        assign stall_hit  = pc_valid[h] && (stall_next >= STALL_MAX);
        assign hang[h]    = hang_q;

        // Track repeated valid pc; invalid cycles leave the run untouched.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stall_cnt <= '0;
                last_pc   <= '0;
            end else if ((state == S_RUN) && pc_valid[h]) begin
                stall_cnt <= stall_next;
                last_pc   <= hpc;
            end
        end

        // Hang flag is set only when the stall detector ends the run.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hang_q <= 1'b0;
            end else if ((state == S_RUN) && !end_hit && stall_hit) begin
                hang_q <= 1'b1;
            end
        end
`else
        assign stall_hit = 1'b0;
        assign hang[h]   = 1'b0;
`endif

        // Shadow of the result register; no bypass into the end check.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow <= '0;
            end else if (res_write) begin
                shadow <= rf_wdata[h*XLEN +: XLEN];
            end
        end

        // Per-hart FSM; END_PC match outranks stall and global timeout.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= S_RUN;
                code  <= '0;
            end else if (state == S_RUN) begin
                if (end_hit) begin
                    if (shadow == XLEN'(1)) begin
                        state <= S_PASS;
                    end else begin
                        state <= S_FAIL;
                        code  <= shadow >> 1;
                    end
                end else if (stall_hit || timeout_hit) begin
                    state <= S_TIMEOUT;
                end
            end
        end
    end

endmodule

// File: tb/tb_test_monitor.sv
// Randomized scoreboard bench for test_monitor (two harts, short timeout).
// Define TEST_MONITOR_STALL_DETECT_EN for both bench and RTL to cover hangs.
module tb_test_monitor;

    localparam int XL   = 32;
    localparam int NH   = 2;
    localparam int TO   = 300;
    localparam int CW   = 16;
    localparam int SL   = 16;
    localparam int RR   = 3;
    localparam int MAXL = TO + 8;
    localparam logic [31:0] ENDPC = 32'h44;
`ifdef TEST_MONITOR_STALL_DETECT_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    localparam logic [2:0] ST_PASS = 3'b100;
    localparam logic [2:0] ST_FAIL = 3'b010;
    localparam logic [2:0] ST_TO   = 3'b001;

    logic              clk = 1'b0;
    logic              rst;
    logic [NH*XL-1:0]  pc;
    logic [NH-1:0]     pc_valid;
    logic [NH-1:0]     rf_we;
    logic [NH*5-1:0]   rf_waddr;
    logic [NH*XL-1:0]  rf_wdata;
    logic [NH-1:0]     hart_pass, hart_fail, hart_timeout, hang;
    logic [NH*XL-1:0]  fail_code;
    logic              done, pass;
    logic [CW-1:0]     cycles;

    always #5 clk = ~clk;

    test_monitor #(
        .XLEN(XL), .NUM_HARTS(NH), .END_PC(ENDPC), .RESULT_REG(RR),
        .TIMEOUT(TO), .TIMEOUT_W(CW), .STALL_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hart_pass(hart_pass), .hart_fail(hart_fail),
        .hart_timeout(hart_timeout), .fail_code(fail_code),
        .hang(hang), .done(done), .pass(pass), .cycles(cycles)
    );

    typedef struct {
        int          hart;
        logic [2:0]  st;
        logic [31:0] code;
        logic        hg;
        int          cyc;
    } hev_t;

    typedef struct {
        int   cyc;
        logic ok;
    } dev_t;

    hev_t hq[$];
    dev_t dq[$];

    int checks = 0;
    int fails  = 0;

    logic [31:0] p_pc [NH][MAXL];
    bit          p_v  [NH][MAXL];
    bit          p_we [NH][MAXL];
    logic [4:0]  p_wa [NH][MAXL];
    logic [31:0] p_wd [NH][MAXL];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a hart or the whole run terminates.
    logic [NH-1:0] prev_term;
    logic          prev_done;
    always @(negedge clk) begin
        if (rst) begin
            prev_term = '0;
            prev_done = 1'b0;
        end else begin
            for (int h = 0; h < NH; h++) begin
                logic term;
                term = hart_pass[h] | hart_fail[h] | hart_timeout[h];
                if (term && !prev_term[h]) begin
                    if (hq.size() == 0) begin
                        check("unexpected_hart_status", 64'(h), 64'hff);
                    end else begin
                        hev_t e;
                        e = hq.pop_front();
                        check("event_hart", 64'(h), 64'(e.hart));
                        check("status", {hart_pass[h], hart_fail[h],
                              hart_timeout[h]}, 64'(e.st));
                        check("fail_code", fail_code[h*XL +: XL], 64'(e.code));
                        check("hang", 64'(hang[h]), 64'(e.hg));
                        check("status_cycles", 64'(cycles), 64'(e.cyc));
                    end
                end
                prev_term[h] = term;
            end
            if (done && !prev_done) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", 64'(cycles), 64'hffff);
                end else begin
                    dev_t d;
                    d = dq.pop_front();
                    check("done_cycles", 64'(cycles), 64'(d.cyc));
                    check("done_pass", 64'(pass), 64'(d.ok));
                end
            end
            prev_done = done;
        end
    end

    task automatic plan_default();
        for (int h = 0; h < NH; h++) begin
            for (int t = 0; t < MAXL; t++) begin
                p_pc[h][t] = 32'h1000 + 32'(h) * 32'h10000 + 32'(t) * 4;
                p_v[h][t]  = 1'b1;
                p_we[h][t] = 1'b0;
                p_wa[h][t] = 5'd0;
                p_wd[h][t] = 32'd0;
            end
        end
    endtask

    task automatic plan_end(input int h, input int t);
        p_pc[h][t] = ENDPC;
        p_v[h][t]  = 1'b1;
    endtask

    task automatic plan_write(input int h, input int t, input int a,
                              input logic [31:0] d);
        p_we[h][t] = 1'b1;
        p_wa[h][t] = 5'(a);
        p_wd[h][t] = d;
    endtask

    // Reference: walk each hart's trace and find when and how it terminates.
    task automatic model(input int abort, output int n_edges, output int last);
        int          term [NH];
        logic [2:0]  st   [NH];
        logic [31:0] code [NH];
        bit          hg   [NH];
        bit          allp;
        last = 0;
        allp = 1'b1;
        for (int h = 0; h < NH; h++) begin
            logic [31:0] shadow, lastpc;
            int run;
            shadow = 0; lastpc = 0; run = 0;
            hg[h] = 1'b0; code[h] = 0; st[h] = ST_TO; term[h] = TO - 1;
            for (int t = 0; t < TO; t++) begin
                if (p_v[h][t] && p_pc[h][t] == ENDPC) begin
                    st[h]   = (shadow == 1) ? ST_PASS : ST_FAIL;
                    code[h] = (shadow == 1) ? 32'd0 : shadow >> 1;
                    term[h] = t;
                    break;
                end
                if (STALL && p_v[h][t]) begin
                    run = (run > 0 && p_pc[h][t] == lastpc) ? run + 1 : 1;
                    lastpc = p_pc[h][t];
                    if (run >= SL) begin
                        hg[h] = 1'b1; term[h] = t;
                        break;
                    end
                end
                if (p_we[h][t] && p_wa[h][t] == 5'(RR)) shadow = p_wd[h][t];
            end
            if (term[h] + 1 > last) last = term[h] + 1;
            if (st[h] != ST_PASS) allp = 1'b0;
        end
        for (int c = 1; c <= TO; c++) begin
            for (int h = 0; h < NH; h++) begin
                if (term[h] + 1 == c && c <= abort) begin
                    hev_t e;
                    e.hart = h; e.st = st[h]; e.code = code[h];
                    e.hg = hg[h]; e.cyc = c;
                    hq.push_back(e);
                end
            end
        end
        if (last <= abort) begin
            dev_t d;
            d.cyc = last; d.ok = allp;
            dq.push_back(d);
        end
        n_edges = (abort < last) ? abort : last + 4;
    endtask

    task automatic apply(input int t);
        for (int h = 0; h < NH; h++) begin
            pc[h*XL +: XL]       = p_pc[h][t];
            pc_valid[h]          = p_v[h][t];
            rf_we[h]             = p_we[h][t];
            rf_waddr[h*5 +: 5]   = p_wa[h][t];
            rf_wdata[h*XL +: XL] = p_wd[h][t];
        end
    endtask

    task automatic check_cleared(input string nm);
        check({nm, "_status"}, {hart_pass, hart_fail, hart_timeout}, 0);
        check({nm, "_done_pass"}, {done, pass}, 0);
        check({nm, "_cycles"}, 64'(cycles), 0);
        check({nm, "_fail_code"}, 64'(fail_code), 0);
        check({nm, "_hang"}, 64'(hang), 0);
    endtask

    task automatic run_episode(input int abort);
        int n, last;
        rst = 1'b1;
        pc = '0; pc_valid = '0; rf_we = '0; rf_waddr = '0; rf_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        model(abort, n, last);
        rst = 1'b0;
        for (int t = 0; t < n; t++) begin
            apply(t);
            @(posedge clk);
            #1;
        end
        if (abort < last) begin
            rst = 1'b1;
            #1;
            check_cleared("abort");
        end else begin
            check("hold_cycles", 64'(cycles), 64'(last));
            check("hold_done", 64'(done), 1);
        end
        @(negedge clk);
        check("hart_queue_left", 64'(hq.size()), 0);
        check("done_queue_left", 64'(dq.size()), 0);
        hq.delete();
        dq.delete();
    endtask

    task automatic plan_random();
        plan_default();
        for (int h = 0; h < NH; h++) begin
            if ($urandom_range(1, 0) == 1) plan_write(h, 0, RR, 32'd1);
            for (int t = 1; t < MAXL; t++) begin
                if ($urandom_range(4, 0) == 0) p_v[h][t] = 1'b0;
                if ($urandom_range(3, 0) == 0) begin
                    int a;
                    a = ($urandom_range(2, 0) == 0) ? RR : int'($urandom_range(31, 0));
                    plan_write(h, t, a, ($urandom_range(3, 0) == 0)
                               ? $urandom : 32'($urandom_range(7, 0)));
                end
            end
            if (STALL && $urandom_range(3, 0) == 0) begin
                int s;
                s = int'($urandom_range(TO - 10, 1));
                for (int t = s; t < s + 40 && t < MAXL; t++)
                    p_pc[h][t] = p_pc[h][s];
            end
            if ($urandom_range(3, 0) != 0)
                plan_end(h, int'($urandom_range(TO + 5, 0)));
        end
    endtask

    initial begin
        prev_term = '0;
        prev_done = 1'b0;

        // Pass on both harts; a write to another register is ignored.
        plan_default();
        plan_write(0, 10, RR, 32'd1);
        plan_write(0, 20, 4, 32'd7);
        plan_end(0, 40);
        plan_write(1, 5, RR, 32'd1);
        plan_end(1, 20);
        run_episode(TO + 10);

        // Failing test number 2 on hart0.
        plan_default();
        plan_write(0, 3, RR, 32'd5);
        plan_end(0, 30);
        plan_write(1, 2, RR, 32'd1);
        plan_end(1, 12);
        run_episode(TO + 10);

        // Nobody reaches END_PC.
        plan_default();
        run_episode(TO + 10);

        // Same-cycle write is not bypassed; END_PC beats the timeout edge.
        plan_default();
        plan_write(0, 7, RR, 32'd1);
        plan_end(0, 7);
        plan_write(1, 4, RR, 32'd7);
        plan_write(1, TO - 1, RR, 32'd1);
        plan_end(1, TO - 1);
        run_episode(TO + 10);

        // Two harts finishing apart, aborted mid-run, then rerun.
        for (int k = 0; k < 2; k++) begin
            plan_default();
            plan_write(0, 5, RR, 32'd1);
            plan_end(0, 100);
            plan_write(1, 6, RR, 32'd1);
            plan_end(1, 200);
            run_episode(k == 0 ? 150 : TO + 10);
        end

        // hart1 spins on one pc with interleaved invalid cycles.
        plan_default();
        plan_write(0, 1, RR, 32'd1);
        plan_end(0, 50);
        for (int t = 0; t < MAXL; t++) begin
            p_pc[1][t] = (t % 5 == 4) ? 32'h200 : 32'h100;
            p_v[1][t]  = (t % 5 != 4);
        end
        run_episode(TO + 10);

        for (int r = 0; r < 20; r++) begin
            plan_random();
            run_episode(TO + 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 Parameter XLEN, default 32, data and PC width.
REQ-002 Parameter NUM_HARTS, default 1, number of monitored harts (channels).
REQ-003 Parameter END_PC, default 32'h44, end-of-test PC.
REQ-004 Parameter RESULT_REG, default 3, register index holding the test result (gp); must be 1..31.
REQ-005 Parameter TIMEOUT, default 5000, maximum run cycles; TIMEOUT_W, default 32, cycle counter width.
REQ-006 Parameter STALL_LIMIT, default 64, hang-detect cycle count (used only under the macro in the Configuration section).
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 pc  in  NUM_HARTS*XLEN  current PC per hart; hart h occupies bits [h*XLEN +: XLEN].
REQ-010 pc_valid  in  NUM_HARTS  per-hart qualifier for pc.
REQ-011 rf_we  in  NUM_HARTS  per-hart register-file write enable.
REQ-012 rf_waddr  in  NUM_HARTS*5  per-hart write register index.
REQ-013 rf_wdata  in  NUM_HARTS*XLEN  per-hart write data.
REQ-014 hart_pass, hart_fail, hart_timeout  out  NUM_HARTS each  per-hart sticky status.
REQ-015 fail_code  out  NUM_HARTS*XLEN  per-hart failing test number.
REQ-016 hang  out  NUM_HARTS  per-hart hang flag.
REQ-017 done  out  1  all harts terminal; pass  out  1  all harts passed.
REQ-018 cycles  out  TIMEOUT_W  run-cycle count, frozen at done.

Function
REQ-019 Each hart SHALL keep a shadow of RESULT_REG, updated on rf_we with rf_waddr==RESULT_REG; writes to other indices SHALL be ignored.
REQ-020 Each hart SHALL run an FSM with states RUN, PASS, FAIL, TIMEOUT; PASS, FAIL and TIMEOUT are sticky until reset.
REQ-021 RUN -> PASS when pc_valid and pc==END_PC and shadow==1; RUN -> FAIL when pc_valid and pc==END_PC and shadow!=1.
REQ-022 The end check SHALL use the shadow value held before the current edge; a same-cycle write to RESULT_REG SHALL NOT be bypassed.
REQ-023 On FAIL, fail_code SHALL latch shadow>>1 (zero-extended); fail_code SHALL be 0 otherwise.
REQ-024 cycles SHALL increment by 1 each cycle while any hart is in RUN, saturating at all-ones.
REQ-025 When cycles==TIMEOUT-1 at an edge, every hart still in RUN SHALL enter TIMEOUT on that edge.
REQ-026 A same-edge END_PC match and timeout SHALL resolve in favour of the END_PC match.
REQ-027 Status outputs SHALL be driven from state registers, visible the cycle after the qualifying inputs.
REQ-028 done = all harts non-RUN; pass = done AND all hart_pass; both derived combinationally from state registers, so they appear in the same cycle as the last hart status.
REQ-029 Once done is asserted, cycles, status and fail_code SHALL hold until reset.

Reset
REQ-030 rst SHALL asynchronously force all harts to RUN, shadows to 0, cycles to 0, fail_code to 0, hang to 0, and all status outputs, done and pass to 0.
REQ-031 Reset asserted mid-run SHALL discard all progress; counting restarts on the first edge after deassertion.

Configuration
REQ-032 Macro TEST_MONITOR_STALL_DETECT_EN SHALL compile in per-hart hang detection.
REQ-033 With the macro defined, a hart in RUN whose valid pc is unchanged (and !=END_PC) for STALL_LIMIT consecutive valid cycles SHALL enter TIMEOUT with hang=1; the stall count SHALL reset on any pc change; invalid cycles SHALL neither increment nor clear it.
REQ-034 Without the macro, no stall counters SHALL exist, hang SHALL be tied 0, and hangs are caught only by TIMEOUT.

Verification
REQ-035 NUM_HARTS=1; write x3=1 at cycle 10, pc=0x44 at cycle 40 -> hart_pass=1, done=1, pass=1, cycles=41, fail_code=0.
REQ-036 Write x3=5, then pc=0x44 -> hart_fail=1, fail_code=2, done=1, pass=0.
REQ-037 Never reach 0x44, TIMEOUT=5000 -> hart_timeout=1 and done=1 after the 5000th edge, cycles=5000, pass=0.
REQ-038 Same cycle: rf_we x3=1 and pc=0x44 with shadow 0 -> FAIL, fail_code=0; a simultaneous timeout still yields FAIL.
REQ-039 NUM_HARTS=2; hart0 passes at cycle 100, hart1 at cycle 200 -> done stays 0 until hart1 status appears, then pass=1, cycles=201; rst at cycle 150 in a rerun clears hart0 status.
REQ-040 With TEST_MONITOR_STALL_DETECT_EN, STALL_LIMIT=64, pc held at 0x100 -> hang=1, hart_timeout=1 after 64 valid cycles; without the macro -> hang=0, timeout only at TIMEOUT.
